// File: rtl/spi_gen_pkg.sv
// Shared types for the generic SPI slave.
// No logic; state encoding and mode bundle only.
// Imported by spi_slave_gen.
package spi_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/sclk_edge_det.sv
// Synchronises SCLK into clk and decodes leading/trailing edges.
// Latency: pin edge is captured by ff1, decode valid while ff1 != ff2.
// No backpressure; one-cycle pulses.
module sclk_edge_det #(
  parameter bit CPOL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  output logic lead,
  output logic trail
);

  logic ff1;
  logic ff2;

  // two-flop synchroniser, idles at the SCLK idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1 <= CPOL;
      ff2 <= CPOL;
    end else begin
      ff1 <= sclk;
      ff2 <= ff1;
    end
  end

  // leaving the idle level is the leading edge, returning to it the trailing edge
  assign lead  = (ff1 != CPOL) && (ff2 == CPOL);
  assign trail = (ff1 == CPOL) && (ff2 != CPOL);

endmodule

// File: rtl/spi_slave_gen.sv
// Parametrised SPI slave: WIDTH-bit words, CPOL/CPHA modes, multi-word frames.
// Latency: status pulses registered one clk after the synchronised edge decode.
// No backpressure: an empty tx holding register simply resends its contents.
module spi_slave_gen
  import spi_gen_pkg::*;
#(
  parameter int          WIDTH  = 16,
  parameter bit          CPOL   = 1'b1,
  parameter bit          CPHA   = 1'b1,
  parameter bit          ECHO   = 1'b1,
  parameter logic [31:0] RST_TX = 32'h0000_ABCD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_ld,
  output logic             tx_req,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_vld,
  output logic             rdy,
  output logic             frm_err
);

  localparam int              CNT_W   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] TX_INIT = RST_TX[WIDTH-1:0];
  localparam spi_mode_t        MODE    = '{cpol: CPOL, cpha: CPHA};

  state_t           state;
  logic [WIDTH-1:0] tx_buf;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] rx_next;
  logic [CNT_W-1:0] bit_cnt;
  logic             word_done;
  logic             lead;
  logic             trail;
  logic             sample_edge;
  logic             shift_edge;

  sclk_edge_det #(
    .CPOL (MODE.cpol)
  ) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sclk  (SCLK),
    .lead  (lead),
    .trail (trail)
  );

  assign sample_edge = MODE.cpha ? trail : lead;
  assign shift_edge  = MODE.cpha ? lead  : trail;
  assign rx_next     = {rx_sr[WIDTH-2:0], MOSI};
  assign MISO        = SS_n ? 1'bz : tx_sr[WIDTH-1];

  // frame FSM, shift registers, tx holding register and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_buf    <= TX_INIT;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data   <= '0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
      rx_vld    <= 1'b0;
      tx_req    <= 1'b0;
      rdy       <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      rx_vld  <= 1'b0;
      tx_req  <= 1'b0;
      frm_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!SS_n) begin
            rdy       <= 1'b0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            tx_sr     <= tx_buf;
            tx_req    <= 1'b1;
            state     <= MODE.cpha ? ARM : ACTIVE;
          end
        end
        ARM: begin
          if (SS_n) begin
            state <= IDLE;
            rdy   <= 1'b1;
          end else if (shift_edge) begin
            // MSB is already on MISO, so the first shift edge only arms sampling
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (SS_n) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            word_done <= 1'b0;
            // a partial word is dropped; rx_data keeps the last complete word
            if (bit_cnt != '0) frm_err <= 1'b1;
          end else begin
            if (sample_edge) begin
              rx_sr <= rx_next;
              if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                rx_data   <= rx_next;
                rx_vld    <= 1'b1;
                bit_cnt   <= '0;
                word_done <= 1'b1;
                if (ECHO) tx_buf <= rx_next;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (shift_edge) begin
              if (word_done) begin
                tx_sr     <= tx_buf;
                tx_req    <= 1'b1;
                word_done <= 1'b0;
              end else begin
                tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
      // host load is last so it overrides an echo write in the same cycle
      if (tx_ld) tx_buf <= tx_data;
    end
  end

endmodule

// File: tb/tb_spi_slave_gen.sv
// Bench for spi_slave_gen: default 16-bit mode-3 echo instance and an
// 8-bit mode-0 instance without echo driven with multi-word frames.
module tb_spi_slave_gen;

  localparam int H = 8;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A: WIDTH=16, CPOL=1, CPHA=1, ECHO=1
  logic        ss_a = 1'b1, sclk_a = 1'b1, mosi_a = 1'b0, tx_ld_a = 1'b0;
  logic [15:0] tx_data_a = '0;
  wire         miso_a;
  logic        tx_req_a, rx_vld_a, rdy_a, frm_err_a;
  logic [15:0] rx_data_a;

  spi_slave_gen u_a (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_a), .SCLK(sclk_a), .MOSI(mosi_a),
    .MISO(miso_a), .tx_data(tx_data_a), .tx_ld(tx_ld_a), .tx_req(tx_req_a),
    .rx_data(rx_data_a), .rx_vld(rx_vld_a), .rdy(rdy_a), .frm_err(frm_err_a)
  );

  // instance B: WIDTH=8, CPOL=0, CPHA=0, ECHO=0
  logic       ss_b = 1'b1, sclk_b = 1'b0, mosi_b = 1'b0, tx_ld_b = 1'b0;
  logic [7:0] tx_data_b = '0;
  wire        miso_b;
  logic       tx_req_b, rx_vld_b, rdy_b, frm_err_b;
  logic [7:0] rx_data_b;

  spi_slave_gen #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .ECHO(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_b), .SCLK(sclk_b), .MOSI(mosi_b),
    .MISO(miso_b), .tx_data(tx_data_b), .tx_ld(tx_ld_b), .tx_req(tx_req_b),
    .rx_data(rx_data_b), .rx_vld(rx_vld_b), .rdy(rdy_b), .frm_err(frm_err_b)
  );

  int total = 0;
  int bad = 0;

  // pulse counters, sampled away from the active edge
  int nvld_a = 0, nreq_a = 0, nfrm_a = 0;
  int nvld_b = 0, nreq_b = 0, nfrm_b = 0;
  logic [7:0] rxw_b [3];
  always @(negedge clk) begin
    if (rx_vld_a)  nvld_a++;
    if (tx_req_a)  nreq_a++;
    if (frm_err_a) nfrm_a++;
    if (rx_vld_b) begin
      if (nvld_b < 3) rxw_b[nvld_b] = rx_data_b;
      nvld_b++;
    end
    if (tx_req_b)  nreq_b++;
    if (frm_err_b) nfrm_b++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode-3 master for A; stop_bits>0 aborts the frame after that many bits,
  // collide asserts tx_ld=BEEF around the final sample edge of word 0
  task automatic xfer_a(input logic [15:0] w0, input logic [15:0] w1,
                        input int nwords, input int stop_bits, input bit collide,
                        output logic [15:0] m0, output logic [15:0] m1);
    logic [31:0] mo;
    logic [31:0] mi;
    int nb;
    mo = {w0, w1};
    mi = '0;
    nb = (stop_bits > 0) ? stop_bits : 16 * nwords;
    ss_a = 1'b0;
    wait_clk(4);
    for (int k = 0; k < nb; k++) begin
      sclk_a = 1'b0;
      mosi_a = mo[31-k];
      wait_clk(H);
      mi[31-k] = miso_a;
      sclk_a = 1'b1;
      if (collide && k == 15) begin
        tx_data_a = 16'hBEEF;
        tx_ld_a   = 1'b1;
      end
      wait_clk(3);
      tx_ld_a = 1'b0;
      wait_clk(H - 3);
    end
    ss_a = 1'b1;
    wait_clk(H);
    m0 = mi[31:16];
    m1 = mi[15:0];
  endtask

  // host side of B: reload the holding register each time it is consumed
  logic [7:0] b_ld [3];
  int ld_idx = 0;
  task automatic wait_b(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_ld_b = 1'b0;
      if (tx_req_b && ld_idx < 3) begin
        tx_data_b = b_ld[ld_idx];
        tx_ld_b   = 1'b1;
        ld_idx++;
      end
    end
  endtask

  typedef struct {
    logic [15:0] mosi;
    logic [15:0] exp_miso;
  } vec_t;
  vec_t tbl [4];

  initial begin
    logic [15:0] m0, m1;
    logic [23:0] bmo, bmi;
    int v0, q0, f0;

    tbl[0] = '{16'h1234, 16'hABCD};
    tbl[1] = '{16'h5555, 16'h1234};
    tbl[2] = '{16'hA5A5, 16'h5555};
    tbl[3] = '{16'h0F0F, 16'hA5A5};
    b_ld[0] = 8'hB2; b_ld[1] = 8'hC3; b_ld[2] = 8'h00;

    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);

    // reset state
    chk("rst_rx_data_a", 32'(rx_data_a), 32'h0);
    chk("rst_flags_a", {28'h0, rx_vld_a, tx_req_a, rdy_a, frm_err_a}, 32'h0);
    chk("rst_rx_data_b", 32'(rx_data_b), 32'h0);
    chk("rst_flags_b", {28'h0, rx_vld_b, tx_req_b, rdy_b, frm_err_b}, 32'h0);

    // single-word frames with echo
    for (int i = 0; i < 4; i++) begin
      v0 = nvld_a; q0 = nreq_a; f0 = nfrm_a;
      xfer_a(tbl[i].mosi, 16'h0, 1, 0, 1'b0, m0, m1);
      chk($sformatf("v%0d_miso", i), 32'(m0), 32'(tbl[i].exp_miso));
      chk($sformatf("v%0d_rx_data", i), 32'(rx_data_a), 32'(tbl[i].mosi));
      chk($sformatf("v%0d_vld_cnt", i), nvld_a - v0, 1);
      chk($sformatf("v%0d_req_cnt", i), nreq_a - q0, 1);
      chk($sformatf("v%0d_frm_cnt", i), nfrm_a - f0, 0);
      chk($sformatf("v%0d_rdy", i), 32'(rdy_a), 32'h1);
    end

    // frame aborted after 5 bits
    v0 = nvld_a; f0 = nfrm_a;
    xfer_a(16'hFFFF, 16'h0, 1, 5, 1'b0, m0, m1);
    chk("abort_frm_cnt", nfrm_a - f0, 1);
    chk("abort_vld_cnt", nvld_a - v0, 0);
    chk("abort_rx_data", 32'(rx_data_a), 32'h0F0F);
    chk("abort_rdy", 32'(rdy_a), 32'h1);
    xfer_a(16'h1357, 16'h0, 1, 0, 1'b0, m0, m1);
    chk("after_abort_miso", 32'(m0), 32'h0F0F);
    chk("after_abort_rx", 32'(rx_data_a), 32'h1357);

    // reset mid-word with SS_n held low
    f0 = nfrm_a;
    ss_a = 1'b0;
    wait_clk(4);
    for (int k = 0; k < 5; k++) begin
      sclk_a = 1'b0; mosi_a = 1'b1; wait_clk(H);
      sclk_a = 1'b1; wait_clk(H);
    end
    chk("mid_rdy_low", 32'(rdy_a), 32'h0);
    rst_n = 1'b0;
    wait_clk(2);
    chk("midrst_rx_data", 32'(rx_data_a), 32'h0);
    chk("midrst_flags", {28'h0, rx_vld_a, tx_req_a, rdy_a, frm_err_a}, 32'h0);
    chk("midrst_miso", 32'(miso_a), 32'h0);
    ss_a = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    chk("midrst_no_frm", nfrm_a - f0, 0);
    xfer_a(16'h2468, 16'h0, 1, 0, 1'b0, m0, m1);
    chk("post_rst_miso", 32'(m0), 32'hABCD);
    chk("post_rst_rx", 32'(rx_data_a), 32'h2468);

    // host load collides with echo of 0001: next word must carry BEEF
    v0 = nvld_a;
    xfer_a(16'h0001, 16'hCAFE, 2, 0, 1'b1, m0, m1);
    chk("collide_w0_miso", 32'(m0), 32'h2468);
    chk("collide_w1_miso", 32'(m1), 32'hBEEF);
    chk("collide_rx", 32'(rx_data_a), 32'hCAFE);
    chk("collide_vld_cnt", nvld_a - v0, 2);

    // B: three 8-bit words in one frame, mode 0, host reloads on tx_req
    tx_data_b = 8'hA1;
    tx_ld_b = 1'b1;
    wait_clk(1);
    tx_ld_b = 1'b0;
    bmo = 24'h0FF03C;
    bmi = '0;
    ss_b = 1'b0;
    mosi_b = bmo[23];
    wait_b(4);
    for (int k = 0; k < 24; k++) begin
      bmi[23-k] = miso_b;
      sclk_b = 1'b1;
      wait_b(H);
      sclk_b = 1'b0;
      if (k < 23) mosi_b = bmo[22-k];
      wait_b(H);
    end
    ss_b = 1'b1;
    wait_b(H);
    chk("b_miso_w0", 32'(bmi[23:16]), 32'hA1);
    chk("b_miso_w1", 32'(bmi[15:8]), 32'hB2);
    chk("b_miso_w2", 32'(bmi[7:0]), 32'hC3);
    chk("b_vld_cnt", nvld_b, 3);
    chk("b_rx_w0", 32'(rxw_b[0]), 32'h0F);
    chk("b_rx_w1", 32'(rxw_b[1]), 32'hF0);
    chk("b_rx_w2", 32'(rxw_b[2]), 32'h3C);
    chk("b_req_cnt", nreq_b, 4);
    chk("b_frm_cnt", nfrm_b, 0);
    chk("b_rdy", 32'(rdy_b), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
